rvc_packer: RTL and testbench
=============================

# rvc_packer

Packs a stream of 32-bit and 16-bit (RVC) RISC-V instructions into 32-bit memory words in instruction-cache byte order, with 32-bit instructions allowed to straddle word boundaries. It sits at the end of the compression flow and is the writer for the fetch-side aligner/decompressor, which consumes these words. Output words are byte-reversed relative to the logical little-endian halfword packing.

## Interface
- ADDR_W, 10, width of the output word address counter
- NOP_HALF, 16'h0001, c.nop halfword used to pad a trailing odd halfword
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_instr  in  32  instruction; for 16-bit beats only [15:0] is used
- in_half  in  1  1 = beat is a 16-bit RVC halfword, 0 = 32-bit instruction
- in_last  in  1  beat is the final instruction of the program
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts word when out_valid && out_ready
- out_word  out  32  packed word, cache byte order
- out_addr  out  ADDR_W  word index of out_word, starting at 0
- out_last  out  1  out_word is the final word of the program
- done  out  1  one-cycle pulse when the out_last word is accepted
- err  out  1  sticky encoding error

## Operation
- Logical word w = {upper_half, lower_half}; out_word = {w[7:0], w[15:8], w[23:16], w[31:24]}.
- State: pend_v/pend_h[15:0] (one pending lower halfword), FSM S_RUN, S_PAD, S_END.
- S_RUN, accepted beat:
  - no pend, 32-bit: emit {i[31:16], i[15:0]}.
  - no pend, 16-bit: pend_h = i[15:0], pend_v = 1, no word.
  - pend, 16-bit: emit {i[15:0], pend_h}, pend_v = 0.
  - pend, 32-bit: emit {i[15:0], pend_h}, pend_h = i[31:16], pend_v stays 1.
- in_last beat: if pend_v is 0 afterwards, the emitted word carries out_last and FSM -> S_END; if pend_v is 1 afterwards, FSM -> S_PAD; a 16-bit last beat with no pend goes to S_PAD.
- S_PAD: when the output register is free, emit {NOP_HALF, pend_h} with out_last, clear pend_v, -> S_END.
- S_END: in_ready = 0; stays until reset.
- out_addr increments (mod 2^ADDR_W, wraps silently) on each accepted output word.
- err set (sticky) on accepted beat with in_half=0 && in_instr[1:0]!=2'b11 && in_instr!=0, or in_half=1 && in_instr[1:0]==2'b11. The beat is still packed as flagged.

## Timing
- Reset values: in_ready 0 during reset, out_valid 0, out_word 0, out_addr 0, out_last 0, done 0, err 0, pend_v 0, FSM S_RUN.
- One-entry registered output. in_ready = (state==S_RUN) && (!out_valid || out_ready).
- Latency: a word appears on out_valid the cycle after the completing beat is accepted.
- out_word, out_addr, out_last are held stable while out_valid && !out_ready.
- Beats that complete no word still require in_ready. There is no bubble at full throughput when out_ready=1.
- S_PAD emission costs one extra cycle after the last beat.
- done is asserted in the same cycle as the out_valid && out_ready handshake of the out_last word.
- Synchronous reset mid-stream discards the pending halfword and the output register. Nothing is flushed.

## Structure
- Shared package rvc_pkg holds the NOP_HALF default, the FSM state enum, and a byte_rev32 function. The same function is reused by the aligner's input swap.
- Single module, no sub-module. The packing datapath is a mux on {pend_v, in_half}.

## Test plan
- 32-bit only: beats 0x00000013, 0x00100093 with out_ready=1 -> out_word 0x13000000 at addr 0, then 0x93001000 at addr 1. The second carries out_last, and done pulses on its handshake.
- Two RVC beats 0x0001 and 0x4501 -> a single word, logical 0x45010001, out_word 0x01000145 at addr 0.
- Straddle: RVC 0x4501, then 32-bit 0x00A00593 (last) -> word logical 0x05934501, then padded word logical 0x000100A0 with out_last. Both appear at the output.
- Backpressure: hold out_ready=0 for 5 cycles with a word pending -> in_ready=0, out_word/out_addr stable. After release, the stream continues with no loss or duplication.
- Error flag: 32-bit beat 0x00000001 -> err=1 and remains 1. A later valid beat packs normally.
- Reset mid-stream with pend_v=1 -> all outputs return to reset values. The next program starts at addr 0 with no stale halfword.

Source files
------------

// File: rtl/rvc_pkg.sv
// Shared definitions for the RVC packing / aligning pair.
package rvc_pkg;

  localparam logic [15:0] NOP_HALF_DEF = 16'h0001;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_PAD = 2'd1,
    S_END = 2'd2
  } state_t;

  // Logical little-endian word to instruction-cache byte order (and back).
  function automatic logic [31:0] byte_rev32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/rvc_packer.sv
// Packs 32-bit and 16-bit RISC-V instructions into 32-bit cache-order words.
// A 32-bit instruction may straddle two words; a trailing odd halfword is
// padded with a c.nop so the final word is always complete.
module rvc_packer
  import rvc_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] NOP_HALF = NOP_HALF_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              in_half,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  state_t      state;
  logic        pend_v;
  logic [15:0] pend_h;

  logic        out_free;
  logic        in_fire;
  logic        emit;
  logic [31:0] word_log;
  logic        pend_v_nxt;
  logic [15:0] pend_h_nxt;
  logic        bad_enc;

  assign out_free = !out_valid || out_ready;
  assign in_ready = rst_n && (state == S_RUN) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign done     = out_valid && out_ready && out_last;

  // A 32-bit beat that is not 32-bit encoded (all-zero is tolerated) or a
  // halfword carrying a 32-bit opcode marks the stream as malformed.
  assign bad_enc = in_half ? (in_instr[1:0] == 2'b11)
                           : ((in_instr[1:0] != 2'b11) && (in_instr != 32'h0));

  // Packing datapath: select the logical word and next pending halfword.
  always_comb begin
    emit       = 1'b0;
    word_log   = 32'h0;
    pend_v_nxt = pend_v;
    pend_h_nxt = pend_h;
    case ({pend_v, in_half})
      2'b00: begin
        emit     = 1'b1;
        word_log = in_instr;
      end
      2'b01: begin
        pend_v_nxt = 1'b1;
        pend_h_nxt = in_instr[15:0];
      end
      2'b11: begin
        emit       = 1'b1;
        word_log   = {in_instr[15:0], pend_h};
        pend_v_nxt = 1'b0;
      end
      default: begin
        emit       = 1'b1;
        word_log   = {in_instr[15:0], pend_h};
        pend_h_nxt = in_instr[31:16];
      end
    endcase
  end

  // Sequencer, pending halfword and one-entry registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      pend_v    <= 1'b0;
      pend_h    <= 16'h0;
      out_valid <= 1'b0;
      out_word  <= 32'h0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_addr  <= out_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case (state)
        S_RUN: begin
          if (in_fire) begin
            if (bad_enc) err <= 1'b1;
            pend_v <= pend_v_nxt;
            pend_h <= pend_h_nxt;
            if (emit) begin
              out_valid <= 1'b1;
              out_word  <= byte_rev32(word_log);
              out_last  <= in_last && !pend_v_nxt;
            end
            if (in_last) state <= pend_v_nxt ? S_PAD : S_END;
          end
        end
        S_PAD: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_word  <= byte_rev32({NOP_HALF, pend_h});
            out_last  <= 1'b1;
            pend_v    <= 1'b0;
            state     <= S_END;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_packer.sv
module tb_rvc_packer;

  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    logic              l;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = 32'h0;
  logic              in_half = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              done;
  logic              err;

  int   n_vec = 0;
  int   n_bad = 0;
  int   bp_mode = 0;
  exp_t q[$];

  logic              m_pend_v;
  logic [15:0]       m_pend_h;
  logic [ADDR_W-1:0] m_addr;

  rvc_packer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_half(in_half), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_last(out_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = 1'b0;
    else out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done && !(out_valid && out_ready)) begin
      n_vec++; n_bad++;
      $display("FAIL done_no_handshake: done=1 without output handshake");
    end
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got word=%h addr=%0d last=%b, none expected",
                 out_word, out_addr, out_last);
      end else begin
        e = q.pop_front();
        if (out_word !== e.w || out_addr !== e.a || out_last !== e.l || done !== e.l) begin
          n_bad++;
          $display("FAIL out_word: got word=%h addr=%0d last=%b done=%b, want word=%h addr=%0d last=%b done=%b",
                   out_word, out_addr, out_last, done, e.w, e.a, e.l, e.l);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] w, input int a, input logic l);
    exp_t e;
    e.w = w; e.a = ADDR_W'(a); e.l = l;
    q.push_back(e);
  endtask

  // Independent reference packer: halfword list -> words, reversed with a streaming op.
  task automatic model_emit(input logic [31:0] wl, input logic l);
    exp_t e;
    e.w = {<<8{wl}}; e.a = m_addr; e.l = l;
    q.push_back(e);
    m_addr = m_addr + 1'b1;
  endtask

  task automatic model_beat(input logic [31:0] i, input logic h, input logic l);
    logic [15:0] halves[2];
    int n;
    halves[0] = i[15:0];
    halves[1] = i[31:16];
    n = h ? 1 : 2;
    for (int k = 0; k < n; k++) begin
      if (m_pend_v) begin
        model_emit({halves[k], m_pend_h}, l && (k == n - 1));
        m_pend_v = 1'b0;
      end else begin
        m_pend_h = halves[k];
        m_pend_v = 1'b1;
      end
    end
    if (l && m_pend_v) begin
      model_emit({16'h0001, m_pend_h}, 1'b1);
      m_pend_v = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [31:0] i, input logic h, input logic l);
    bit ok = 0;
    in_valid = 1'b1; in_instr = i; in_half = h; in_last = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL beat_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && q.size() != 0; k++) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL end_in_ready: in_ready=%b, required 0 after program end", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; bp_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_word, out_addr, out_last, done, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b vld=%b word=%h addr=%0d last=%b done=%b err=%b, required all 0",
               in_ready, out_valid, out_word, out_addr, out_last, done, err);
    end
    q.delete();
    m_pend_v = 1'b0; m_pend_h = 16'h0; m_addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word32();
    test_reset();
    push_exp(32'h13000000, 0, 1'b0);
    push_exp(32'h93001000, 1, 1'b1);
    send_beat(32'h00000013, 1'b0, 1'b0);
    send_beat(32'h00100093, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_rvc_pair();
    test_reset();
    push_exp(32'h01000145, 0, 1'b1);
    send_beat(32'h00000001, 1'b1, 1'b0);
    send_beat(32'h00004501, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_straddle();
    test_reset();
    push_exp(32'h01459305, 0, 1'b0);
    push_exp(32'hA0000100, 1, 1'b1);
    send_beat(32'h00004501, 1'b1, 1'b0);
    send_beat(32'h00A00593, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_odd_pad();
    test_reset();
    push_exp(32'h01450100, 0, 1'b1);
    send_beat(32'hFFFF4501, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    bit ok = 0;
    test_reset();
    bp_mode = 1;
    push_exp(32'h13000000, 0, 1'b0);
    send_beat(32'h00000013, 1'b0, 1'b0);
    in_valid = 1'b1; in_instr = 32'h00100093; in_half = 1'b0; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h13000000 || out_addr !== '0) begin
        n_bad++;
        $display("FAIL bp_hold: rdy=%b vld=%b word=%h addr=%0d, required 0 1 13000000 0",
                 in_ready, out_valid, out_word, out_addr);
      end
    end
    push_exp(32'h93001000, 1, 1'b1);
    bp_mode = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_release: in_ready=%b, required 1 after release", in_ready);
    end
    drain();
  endtask

  task automatic test_err();
    test_reset();
    push_exp(32'h01000000, 0, 1'b0);
    push_exp(32'h13000000, 1, 1'b1);
    send_beat(32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: err=%b, required 1", err);
    end
    @(posedge clk); #1;
    send_beat(32'h00000013, 1'b0, 1'b1);
    drain();
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: err=%b, required 1", err);
    end
    test_reset();
    push_exp(32'h13000000, 0, 1'b0);
    send_beat(32'h00000013, 1'b0, 1'b0);
    send_beat(32'h0000FFFF, 1'b1, 1'b0);
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_rvc: err=%b, required 1 for halfword with [1:0]=11", err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midstream_reset();
    test_reset();
    push_exp(32'h13000000, 0, 1'b0);
    send_beat(32'h00000013, 1'b0, 1'b0);
    send_beat(32'h00004501, 1'b1, 1'b0);
    test_reset();
    push_exp(32'h01000145, 0, 1'b1);
    send_beat(32'h00000001, 1'b1, 1'b0);
    send_beat(32'h00004501, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] i;
    logic h, l;
    test_reset();
    bp_mode = 2;
    for (int k = 0; k < 80; k++) begin
      h = 1'($urandom_range(0, 1));
      i = $urandom;
      if (h) i[1:0] = 2'($urandom_range(0, 2));
      else   i[1:0] = 2'b11;
      l = (k == 79);
      model_beat(i, h, l);
      send_beat(i, h, l);
    end
    drain();
    bp_mode = 0;
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL rand_err: err=%b, required 0 for well-formed stream", err);
    end
  endtask

  task automatic test_addr_wrap();
    test_reset();
    for (int k = 0; k < 1030; k++) begin
      model_beat(32'h00000013 + (k << 7), 1'b0, k == 1029);
      send_beat(32'h00000013 + (k << 7), 1'b0, k == 1029);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_word32();
    test_rvc_pair();
    test_straddle();
    test_odd_pad();
    test_backpressure();
    test_err();
    test_midstream_reset();
    test_random();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
